event_counter: RTL

//  Parametrised up/down event counter for game counters (flag count, mine count, timer digits).

---
 rtl/event_counter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/event_counter.sv
// -----------------------------------------------------------------------------
// event_counter
//
// Up/down event counter for game counters such as flag count, mine count and
// timer digits. It counts rising edges of event_in in the clk domain. The upper
// limit is set at runtime. At a bound the counter either wraps or saturates,
// depending on the WRAP parameter. It also supports a synchronous clear and a
// synchronous load.
//
// When a step hits a bound, tc pulses for one cycle. Cascaded digits use this
// pulse to carry into the next digit.
//
// Parameters
//   DATA_SIZE : width of the counter, the limit and the load value
//   WRAP      : 1 = wrap at the bounds (max->0 counting up, 0->max counting
//               down); 0 = saturate at the bounds
//
// Ports
//   clk       in   system clock; all state changes on posedge clk
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable; edges seen while en=0 are dropped
//   event_in  in   event strobe (level); one count per rising edge
//   dir       in   1 = count up, 0 = count down; sampled with the step
//   clr       in   synchronous clear to 0 (highest priority)
//   load      in   synchronous load of load_val (clamped to max)
//   load_val  in   load value
//   max       in   inclusive upper limit
//   ctr_out   out  counter value (registered)
//   tc        out  one-cycle pulse after each step that hits a bound
//   at_max    out  ctr_out >= max (combinational)
//   at_zero   out  ctr_out == 0 (combinational)
//
// Configuration macro
//   EVENT_COUNTER_SYNC_EN : when defined, event_in passes through a two-flop
//   synchroniser before the edge detector. This makes asynchronous sources
//   such as buttons safe. The latency from the event_in rise to the ctr_out
//   change becomes 3 clocks. When the macro is undefined, event_in must be
//   synchronous to clk and the latency is 1 clock.
// -----------------------------------------------------------------------------
module event_counter #(
    parameter int unsigned DATA_SIZE = 5,
    parameter bit          WRAP      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 event_in,
    input  logic                 dir,
    input  logic                 clr,
    input  logic                 load,
    input  logic [DATA_SIZE-1:0] load_val,
    input  logic [DATA_SIZE-1:0] max,
    output logic [DATA_SIZE-1:0] ctr_out,
    output logic                 tc,
    output logic                 at_max,
    output logic                 at_zero
);

    localparam logic [DATA_SIZE-1:0] ZERO = {DATA_SIZE{1'b0}};
    localparam logic [DATA_SIZE-1:0] ONE  = DATA_SIZE'(1'b1);

    logic                 ev_s;
    logic                 step_s;
    logic                 evt_q;
    logic [DATA_SIZE-1:0] ctr_q;
    logic [DATA_SIZE-1:0] ctr_d;
    logic                 tc_q;
    logic                 tc_d;

`ifdef EVENT_COUNTER_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchroniser that brings an asynchronous event_in into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= event_in;
            sync2_q <= sync1_q;
        end
    end

    assign ev_s = sync2_q;
`else
    assign ev_s = event_in;
`endif

    // The edge register updates even while en=0. Because of this, a level
    // that is already high when the counter is re-enabled does not count.
    assign step_s = en & ev_s & ~evt_q;

    // Next-state logic. Priority is clr > load > step. A clear or a load
    // swallows any step in the same cycle, so tc stays low.
    always_comb begin
        ctr_d = ctr_q;
        tc_d  = 1'b0;
        if (clr) begin
            ctr_d = ZERO;
        end else if (load) begin
            if (load_val > max) begin
                ctr_d = max;
            end else begin
                ctr_d = load_val;
            end
        end else if (step_s) begin
            if (dir) begin
                // The ">= max" test also covers a limit lowered below the count.
                if (ctr_q < max) begin
                    ctr_d = ctr_q + ONE;
                end else begin
                    tc_d = 1'b1;
                    if (WRAP) begin
                        ctr_d = ZERO;
                    end else begin
                        ctr_d = max;
                    end
                end
            end else begin
                if (ctr_q != ZERO) begin
                    ctr_d = ctr_q - ONE;
                end else begin
                    tc_d = 1'b1;
                    if (WRAP) begin
                        ctr_d = max;
                    end else begin
                        ctr_d = ZERO;
                    end
                end
            end
        end else begin
            ctr_d = ctr_q;
        end
    end

    // State registers: counter, terminal-count pulse and edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q <= ZERO;
            tc_q  <= 1'b0;
            evt_q <= 1'b0;
        end else begin
            ctr_q <= ctr_d;
            tc_q  <= tc_d;
            evt_q <= ev_s;
        end
    end

    assign ctr_out = ctr_q;
    assign tc      = tc_q;
    assign at_max  = (ctr_q >= max);
    assign at_zero = (ctr_q == ZERO);

endmodule
